register_file_sb: RTL and testbench
===================================

// Module: register_file_sb
// PURPOSE
//  Parametrised register file: 2 combinational read ports, 1 clocked write port.
//  Adds a write-through bypass and a pending-write scoreboard for multi-cycle producers.
//  Sits between decode (reads, issue) and write-back (write) in the datapath.
//  Raises a hazard flag when a source register still awaits its producer's result.
// PARAMETERS
//  DATA_WIDTH  32  bits per register
//  NUM_REGS    32  number of registers (>=2)
//  ADDR_WIDTH  $clog2(NUM_REGS)  register index width
//  ZERO_REG    1   1: register 0 always reads 0, is never written, is never pending
//  BYPASS      1   1: same-cycle write data forwarded to read ports
// PORTS
//  clock          in   1            rising-edge clock
//  reset_n        in   1            asynchronous, active-low reset
//  register1      in   ADDR_WIDTH   read port 1 index
//  register2      in   ADDR_WIDTH   read port 2 index
//  readData1      out  DATA_WIDTH   contents of register1 (bypassed)
//  readData2      out  DATA_WIDTH   contents of register2 (bypassed)
//  regWrite       in   1            write enable
//  writeRegister  in   ADDR_WIDTH   write index
//  writeData      in   DATA_WIDTH   write data
//  issueValid     in   1            a multi-cycle producer is issued this cycle
//  issueRegister  in   ADDR_WIDTH   destination of the issued producer
//  hazard         out  1            a source is pending and not written this cycle
//  pendingCount   out  ADDR_WIDTH+1 number of pending registers
// BEHAVIOUR
//  - Reset (reset_n=0, async): all registers 0, all pending bits 0, pendingCount=0.
//    Reads during reset return 0; hazard=0. Reset mid-operation drops all pending state.
//  - Write: at the rising edge with regWrite=1, regs[writeRegister] <= writeData.
//    ZERO_REG=1 and writeRegister=0: write ignored.
//  - Read: combinational, 0-cycle latency. ZERO_REG=1 and index 0 -> 0.
//    BYPASS=1, regWrite=1, writeRegister==index (not 0) -> writeData, not the stored value.
//  - Out-of-range index (>=NUM_REGS): read returns 0, write ignored, issue ignored.
//  - Scoreboard, one pending bit per register, updated at the clock edge:
//    issueValid sets pending[issueRegister]; regWrite clears pending[writeRegister].
//    Issue and write to the same register in one cycle: set wins (newer producer).
//    Issue of an already-pending register: bit stays 1, count unchanged.
//    Write to a non-pending register: ordinary write, count unchanged.
//  - hazard = OR over p in {1,2}: pending[register_p] AND NOT(regWrite AND writeRegister==register_p).
//    The hazard is cleared by a same-cycle write (requires BYPASS=1; with BYPASS=0 no clear).
//  - pendingCount: registered population of the pending bits.
//    Updated by +1, -1 or 0 per cycle, consistent with the set/clear rules.
//    Never wraps: max NUM_REGS-1 with ZERO_REG=1, else NUM_REGS.
// STRUCTURE
//  - Package regfile_pkg: DATA_WIDTH and NUM_REGS defaults, clog2-based ADDR_WIDTH,
//    and a typedef for the register index and data words.
//  - Sub-module register_scoreboard: pending bits, set/clear priority, pendingCount, hazard.
//  - Top level: storage array, write logic and bypass muxes.
// TESTING
//  1. Reset, then read all indices -> all 0. Write r5=0xDEADBEEF, read r5 next cycle -> 0xDEADBEEF.
//  2. Write r0=0x1234, read r0 -> 0. Issue r0 -> pendingCount stays 0.
//  3. Write r7=0xA5A5A5A5 and read r7 in the same cycle -> readData=0xA5A5A5A5 (BYPASS=1).
//     With BYPASS=0 -> old value.
//  4. Issue r3; next cycle register1=3 -> hazard=1, pendingCount=1.
//     Write r3=0x42 -> hazard=0 that cycle, readData1=0x42; next cycle pendingCount=0.
//  5. r3 pending, then issue r3 and write r3 in the same cycle -> r3 stays pending, count=1.
//  6. Issue r1, r2, r4; pulse reset_n low mid-cycle -> count=0, hazard=0, all reads 0, immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults, word/index types and the index range check for the register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_NUM_REGS   = 32;
  localparam int unsigned DEF_ADDR_WIDTH = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [DEF_DATA_WIDTH-1:0] data_word_t;

  // True when a register index names a physically present register.
  function automatic logic idx_in_range(input int unsigned idx, input int unsigned num_regs);
    return idx < num_regs;
  endfunction

endpackage

// File: rtl/register_scoreboard.sv
// Pending-write scoreboard: one pending bit per register, population count and hazard flag.
module register_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS),
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] writeRegister,
  input  logic                  issueValid,
  input  logic [ADDR_WIDTH-1:0] issueRegister,
  input  logic [ADDR_WIDTH-1:0] register1,
  input  logic [ADDR_WIDTH-1:0] register2,
  output logic                  hazard,
  output logic [ADDR_WIDTH:0]   pendingCount
);

  localparam int unsigned CW = ADDR_WIDTH + 1;

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_nxt;
  logic [CW-1:0]       r_count;
  logic                w_set;
  logic                w_clr;
  logic                w_inc;
  logic                w_dec;
  logic                w_hz1;
  logic                w_hz2;

  // Qualify issue/write: out-of-range and (optionally) register 0 never become pending.
  always_comb begin
    w_set = issueValid && idx_in_range(32'(issueRegister), NUM_REGS)
            && !(ZERO_REG && (issueRegister == '0));
    w_clr = regWrite && idx_in_range(32'(writeRegister), NUM_REGS)
            && !(ZERO_REG && (writeRegister == '0));
  end

  // Next pending vector; the set is applied after the clear so a new producer wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_clr) w_pending_nxt[writeRegister] = 1'b0;
    if (w_set) w_pending_nxt[issueRegister] = 1'b1;
  end

  // Count delta follows the same priority, so the count always equals the population.
  always_comb begin
    w_inc = w_set && !r_pending[issueRegister];
    w_dec = w_clr && r_pending[writeRegister]
            && !(w_set && (issueRegister == writeRegister));
  end

  // Pending bits and their registered population.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_count   <= r_count + CW'(w_inc) - CW'(w_dec);
    end
  end

  // A source is hazardous while pending unless its result is being forwarded this cycle.
  always_comb begin
    w_hz1 = idx_in_range(32'(register1), NUM_REGS) && r_pending[register1]
            && !(BYPASS && regWrite && (writeRegister == register1));
    w_hz2 = idx_in_range(32'(register2), NUM_REGS) && r_pending[register2]
            && !(BYPASS && regWrite && (writeRegister == register2));
    hazard       = w_hz1 || w_hz2;
    pendingCount = r_count;
  end

endmodule

// File: rtl/register_file_sb.sv
// Register file with two combinational read ports, one write port, write-through
// bypass and a pending-write scoreboard for multi-cycle producers.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS),
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] register1,
  input  logic [ADDR_WIDTH-1:0] register2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] writeRegister,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  issueValid,
  input  logic [ADDR_WIDTH-1:0] issueRegister,
  output logic                  hazard,
  output logic [ADDR_WIDTH:0]   pendingCount
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  w_wr_ok;

  // A write lands only on an in-range, non-hardwired register.
  always_comb begin
    w_wr_ok = regWrite && idx_in_range(32'(writeRegister), NUM_REGS)
              && !(ZERO_REG && (writeRegister == '0));
  end

  // Storage array.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[writeRegister] <= writeData;
    end
  end

  // Read port 1; reset also masks the bypass so reads are 0 throughout reset.
  always_comb begin
    readData1 = '0;
    if (reset_n && idx_in_range(32'(register1), NUM_REGS)
        && !(ZERO_REG && (register1 == '0))) begin
      if (BYPASS && w_wr_ok && (writeRegister == register1)) readData1 = writeData;
      else                                                   readData1 = r_regs[register1];
    end
  end

  // Read port 2, same rules as port 1.
  always_comb begin
    readData2 = '0;
    if (reset_n && idx_in_range(32'(register2), NUM_REGS)
        && !(ZERO_REG && (register2 == '0))) begin
      if (BYPASS && w_wr_ok && (writeRegister == register2)) readData2 = writeData;
      else                                                   readData2 = r_regs[register2];
    end
  end

  register_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG),
    .BYPASS    (BYPASS)
  ) u_scoreboard (
    .clock        (clock),
    .reset_n      (reset_n),
    .regWrite     (regWrite),
    .writeRegister(writeRegister),
    .issueValid   (issueValid),
    .issueRegister(issueRegister),
    .register1    (register1),
    .register2    (register2),
    .hazard       (hazard),
    .pendingCount (pendingCount)
  );

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: a BYPASS=1 and a BYPASS=0 instance share stimulus.
module tb_register_file_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [AW-1:0] register1, register2, writeRegister, issueRegister;
  logic          regWrite, issueValid;
  logic [DW-1:0] writeData;

  logic [DW-1:0] rd1, rd2, nb_rd1, nb_rd2;
  logic          hz, nb_hz;
  logic [AW:0]   cnt, nb_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  register_file_sb #(.DATA_WIDTH(DW), .NUM_REGS(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clock(clock), .reset_n(reset_n),
    .register1(register1), .register2(register2),
    .readData1(rd1), .readData2(rd2),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .issueValid(issueValid), .issueRegister(issueRegister),
    .hazard(hz), .pendingCount(cnt)
  );

  register_file_sb #(.DATA_WIDTH(DW), .NUM_REGS(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .clock(clock), .reset_n(reset_n),
    .register1(register1), .register2(register2),
    .readData1(nb_rd1), .readData2(nb_rd2),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .issueValid(issueValid), .issueRegister(issueRegister),
    .hazard(nb_hz), .pendingCount(nb_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; regWrite = 1'b0; issueValid = 1'b0;
    register1 = '0; register2 = '0; writeRegister = '0; issueRegister = '0; writeData = '0;

    // 1: reset state and plain write/read
    #1;
    check_eq("rst_rd1", rd1, 32'h0);
    check_eq("rst_cnt", cnt, 32'h0);
    check_eq("rst_hz", hz, 32'h0);
    #12 reset_n = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      register1 = AW'(i);
      register2 = AW'(31 - i);
      #1;
      check_eq("init_rd1", rd1, 32'h0);
      check_eq("init_rd2", rd2, 32'h0);
    end
    check_eq("init_cnt", cnt, 32'h0);
    check_eq("init_hz", hz, 32'h0);

    regWrite = 1'b1; writeRegister = 5'd5; writeData = 32'hDEADBEEF;
    tick();
    regWrite = 1'b0; register1 = 5'd5; #1;
    check_eq("r5_read", rd1, 32'hDEADBEEF);

    // 2: register 0 is hardwired and never pending
    regWrite = 1'b1; writeRegister = 5'd0; writeData = 32'h1234; register1 = 5'd0; #1;
    check_eq("r0_bypass", rd1, 32'h0);
    tick();
    regWrite = 1'b0; #1;
    check_eq("r0_read", rd1, 32'h0);
    issueValid = 1'b1; issueRegister = 5'd0;
    tick();
    issueValid = 1'b0; #1;
    check_eq("r0_issue_cnt", cnt, 32'h0);

    // 3: same-cycle write/read, with and without bypass
    regWrite = 1'b1; writeRegister = 5'd7; writeData = 32'hA5A5A5A5; register2 = 5'd7; #1;
    check_eq("r7_bypass", rd2, 32'hA5A5A5A5);
    check_eq("r7_nobypass_old", nb_rd2, 32'h0);
    tick();
    regWrite = 1'b0; #1;
    check_eq("r7_nobypass_new", nb_rd2, 32'hA5A5A5A5);

    // 4: issue r3, hazard, cleared by write
    issueValid = 1'b1; issueRegister = 5'd3;
    tick();
    issueValid = 1'b0; register1 = 5'd3; register2 = 5'd7; #1;
    check_eq("r3_hz", hz, 32'h1);
    check_eq("r3_cnt", cnt, 32'h1);
    check_eq("r3_nb_hz", nb_hz, 32'h1);
    regWrite = 1'b1; writeRegister = 5'd3; writeData = 32'h42; #1;
    check_eq("r3_wr_hz", hz, 32'h0);
    check_eq("r3_wr_rd1", rd1, 32'h42);
    check_eq("r3_wr_nb_hz", nb_hz, 32'h1);
    check_eq("r3_wr_nb_rd1", nb_rd1, 32'h0);
    check_eq("r3_wr_cnt_same", cnt, 32'h1);
    tick();
    regWrite = 1'b0; #1;
    check_eq("r3_after_cnt", cnt, 32'h0);
    check_eq("r3_after_hz", hz, 32'h0);
    check_eq("r3_after_nb_cnt", nb_cnt, 32'h0);

    // 5: re-issue, issue+write same register, issue/clear of different registers
    issueValid = 1'b1; issueRegister = 5'd3;
    tick();
    #1 check_eq("p5_cnt1", cnt, 32'h1);
    tick();
    #1 check_eq("p5_reissue_cnt", cnt, 32'h1);
    regWrite = 1'b1; writeRegister = 5'd3; writeData = 32'h99;
    tick();
    issueValid = 1'b0; regWrite = 1'b0; #1;
    check_eq("p5_setwins_cnt", cnt, 32'h1);
    check_eq("p5_setwins_hz", hz, 32'h1);
    check_eq("p5_setwins_rd1", rd1, 32'h99);
    issueValid = 1'b1; issueRegister = 5'd8;
    regWrite = 1'b1; writeRegister = 5'd3; writeData = 32'h77;
    tick();
    issueValid = 1'b0; regWrite = 1'b0; register2 = 5'd8; #1;
    check_eq("p5_swap_cnt", cnt, 32'h1);
    register2 = 5'd7; #1;
    check_eq("p5_r3_clear_hz", hz, 32'h0);
    register2 = 5'd8; #1;
    check_eq("p5_r8_hz", hz, 32'h1);
    regWrite = 1'b1; writeRegister = 5'd8; writeData = 32'h8;
    tick();
    regWrite = 1'b0; #1;
    check_eq("p5_final_cnt", cnt, 32'h0);

    // 6: several pending, then asynchronous reset mid-cycle
    regWrite = 1'b1; writeRegister = 5'd1; writeData = 32'h11;
    tick();
    regWrite = 1'b0;
    issueValid = 1'b1; issueRegister = 5'd1; tick();
    issueRegister = 5'd2; tick();
    issueRegister = 5'd4; tick();
    issueValid = 1'b0; register1 = 5'd1; register2 = 5'd2; #1;
    check_eq("p6_cnt3", cnt, 32'h3);
    check_eq("p6_hz", hz, 32'h1);
    check_eq("p6_r1", rd1, 32'h11);
    #2 reset_n = 1'b0;
    #1;
    check_eq("p6_rst_cnt", cnt, 32'h0);
    check_eq("p6_rst_hz", hz, 32'h0);
    check_eq("p6_rst_rd1", rd1, 32'h0);
    check_eq("p6_rst_rd2", rd2, 32'h0);
    #1 reset_n = 1'b1;
    register1 = 5'd5; register2 = 5'd7;
    tick();
    check_eq("p6_post_r5", rd1, 32'h0);
    check_eq("p6_post_r7", rd2, 32'h0);
    check_eq("p6_post_cnt", cnt, 32'h0);
    check_eq("p6_post_nb_cnt", nb_cnt, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
